// File: rtl/lift_pkg.sv
// Shared types for the SCAN lift controller.
//   lift_state_e : controller FSM state encoding (3 bits)
//   DIR_UP/DOWN  : encoding of the travel-preference bit
package lift_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MOVE_UP   = 3'd1,
        MOVE_DOWN = 3'd2,
        DOOR_OPEN = 3'd3,
        EMERGENCY = 3'd4
    } lift_state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/lift_req_scanner.sv
// Combinational request scanner.
// Reduces the latched request vector relative to the car position.
//   pending [NUM_FLOORS] : latched, unserved floor requests
//   cf      [FLOOR_W]    : current floor of the car
//   above                : any request strictly above cf
//   below                : any request strictly below cf
//   here                 : request at cf
module lift_req_scanner #(
    parameter int NUM_FLOORS = 8,
    parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    cf,
    output logic                  above,
    output logic                  below,
    output logic                  here
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        above = 1'b0;
        below = 1'b0;
        here  = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (FLOOR_W'(i) > cf)       above |= pending[i];
            else if (FLOOR_W'(i) < cf)  below |= pending[i];
            else                        here  |= pending[i];
        end
    end

endmodule

// File: rtl/scan_lift_controller.sv
// N-floor elevator controller with latched requests and SCAN scheduling.
// The car keeps its travel direction while requests remain ahead of it,
// then reverses. Each floor costs TRAVEL_CYCLES, each stop opens the door
// for DOOR_CYCLES, and an emergency hold freezes the car without losing
// pending requests.
//   clk, reset       : clock, synchronous active-high reset
//   floor_req        : per-floor call buttons (level, latched into pending)
//   emergency_stop   : level, forces EMERGENCY while high
//   c_up / c_down    : motor drive
//   motor_stop       : brake engaged
//   door_open        : door open at current_floor
//   direction        : travel preference, 1 = up
//   current_floor    : car position
//   pending          : latched, unserved requests
module scan_lift_controller
    import lift_pkg::*;
#(
    parameter int NUM_FLOORS    = 8,
    parameter int FLOOR_W       = $clog2(NUM_FLOORS),
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] floor_req,
    input  logic                  emergency_stop,
    output logic                  c_up,
    output logic                  c_down,
    output logic                  motor_stop,
    output logic                  door_open,
    output logic                  direction,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int TRAVEL_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DOOR_W   = (DOOR_CYCLES   > 1) ? $clog2(DOOR_CYCLES)   : 1;

    lift_state_e           state_q, state_d;
    logic [FLOOR_W-1:0]    cf_q, cf_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic                  direction_q, direction_d;
    logic [TRAVEL_W-1:0]   travel_cnt_q, travel_cnt_d;
    logic [DOOR_W-1:0]     door_cnt_q, door_cnt_d;
    logic                  c_up_q, c_down_q, motor_stop_q, door_open_q;

    logic above, below, here;
    logic travel_done, door_done, at_top, at_bottom;
    lift_state_e choice_state;
    logic        choice_dir;

    lift_req_scanner #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_scanner (
        .pending (pending_q),
        .cf      (cf_q),
        .above   (above),
        .below   (below),
        .here    (here)
    );

    assign travel_done = (travel_cnt_q == TRAVEL_W'(TRAVEL_CYCLES - 1));
    assign door_done   = (door_cnt_q   == DOOR_W'(DOOR_CYCLES - 1));
    assign at_top      = (cf_q == FLOOR_W'(NUM_FLOORS - 1));
    assign at_bottom   = (cf_q == '0);

    // SCAN direction choice: keep going up while work remains above,
    // otherwise serve below, otherwise turn back up.
    always_comb begin
        choice_state = IDLE;
        choice_dir   = direction_q;
        if (direction_q && above) begin
            choice_state = MOVE_UP;
        end else if (below) begin
            choice_state = MOVE_DOWN;
            choice_dir   = DIR_DOWN;
        end else if (above) begin
            choice_state = MOVE_UP;
            choice_dir   = DIR_UP;
        end
    end

    always_comb begin
        state_d      = state_q;
        cf_d         = cf_q;
        direction_d  = direction_q;
        travel_cnt_d = travel_cnt_q;
        door_cnt_d   = door_cnt_q;
        pending_d    = pending_q | floor_req;

        if (emergency_stop) begin
            // Car position and partial travel count are frozen.
            state_d = EMERGENCY;
        end else begin
            case (state_q)
                IDLE: begin
                    if (here) begin
                        state_d    = DOOR_OPEN;
                        door_cnt_d = '0;
                    end else begin
                        state_d      = choice_state;
                        direction_d  = choice_dir;
                        travel_cnt_d = '0;
                    end
                end
                MOVE_UP: begin
                    if (!travel_done) begin
                        travel_cnt_d = travel_cnt_q + TRAVEL_W'(1);
                    end else if (!at_top) begin
                        cf_d         = cf_q + FLOOR_W'(1);
                        travel_cnt_d = '0;
                        if (pending_q[cf_d]) begin
                            state_d    = DOOR_OPEN;
                            door_cnt_d = '0;
                        end
                    end
                end
                MOVE_DOWN: begin
                    if (!travel_done) begin
                        travel_cnt_d = travel_cnt_q + TRAVEL_W'(1);
                    end else if (!at_bottom) begin
                        cf_d         = cf_q - FLOOR_W'(1);
                        travel_cnt_d = '0;
                        if (pending_q[cf_d]) begin
                            state_d    = DOOR_OPEN;
                            door_cnt_d = '0;
                        end
                    end
                end
                DOOR_OPEN: begin
                    if (floor_req[cf_q]) begin
                        // A call for the open floor just holds the door longer.
                        door_cnt_d = '0;
                    end else if (door_done) begin
                        state_d      = choice_state;
                        direction_d  = choice_dir;
                        travel_cnt_d = '0;
                    end else begin
                        door_cnt_d = door_cnt_q + DOOR_W'(1);
                    end
                end
                EMERGENCY: begin
                    // Release discards any partly travelled floor.
                    state_d      = IDLE;
                    travel_cnt_d = '0;
                end
                default: state_d = IDLE;
            endcase
        end

        // Serving a floor (entering or holding the door) clears its request.
        if (state_d == DOOR_OPEN) pending_d[cf_d] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values computed above.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cf_q         <= '0;
            pending_q    <= '0;
            direction_q  <= DIR_UP;
            travel_cnt_q <= '0;
            door_cnt_q   <= '0;
            c_up_q       <= 1'b0;
            c_down_q     <= 1'b0;
            motor_stop_q <= 1'b1;
            door_open_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cf_q         <= cf_d;
            pending_q    <= pending_d;
            direction_q  <= direction_d;
            travel_cnt_q <= travel_cnt_d;
            door_cnt_q   <= door_cnt_d;
            // Output decode registered from the next state keeps the
            // outputs a pure function of the registered state.
            c_up_q       <= (state_d == MOVE_UP);
            c_down_q     <= (state_d == MOVE_DOWN);
            motor_stop_q <= (state_d == IDLE) || (state_d == EMERGENCY) ||
                            (state_d == DOOR_OPEN);
            door_open_q  <= (state_d == DOOR_OPEN);
        end
    end

    assign c_up          = c_up_q;
    assign c_down        = c_down_q;
    assign motor_stop    = motor_stop_q;
    assign door_open     = door_open_q;
    assign direction     = direction_q;
    assign current_floor = cf_q;
    assign pending       = pending_q;

    // A floor step past either end means the scheduler lost track of work.
    step_up_in_range: assert property (@(posedge clk) disable iff (reset)
        (!emergency_stop && state_q == MOVE_UP && travel_done) |-> !at_top);
    step_down_in_range: assert property (@(posedge clk) disable iff (reset)
        (!emergency_stop && state_q == MOVE_DOWN && travel_done) |-> !at_bottom);

endmodule

// File: tb/tb_scan_lift_controller.sv
// Self-checking bench for scan_lift_controller (8 floors, travel 4, door 8).
// Expected stops (floor, door-open length) are queued as requests are driven
// and compared as each door opening is observed.
module tb_scan_lift_controller;

    localparam int NUM_FLOORS    = 8;
    localparam int FLOOR_W       = 3;
    localparam int TRAVEL_CYCLES = 4;
    localparam int DOOR_CYCLES   = 8;
    localparam int BUDGET        = 300;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NUM_FLOORS-1:0] floor_req;
    logic                  emergency_stop;
    logic                  c_up, c_down, motor_stop, door_open, direction;
    logic [FLOOR_W-1:0]    current_floor;
    logic [NUM_FLOORS-1:0] pending;

    typedef struct {
        int floor;
        int door_len;
    } stop_t;

    stop_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    scan_lift_controller #(
        .NUM_FLOORS    (NUM_FLOORS),
        .FLOOR_W       (FLOOR_W),
        .TRAVEL_CYCLES (TRAVEL_CYCLES),
        .DOOR_CYCLES   (DOOR_CYCLES)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .floor_req      (floor_req),
        .emergency_stop (emergency_stop),
        .c_up           (c_up),
        .c_down         (c_down),
        .motor_stop     (motor_stop),
        .door_open      (door_open),
        .direction      (direction),
        .current_floor  (current_floor),
        .pending        (pending)
    );

    always #5 clk = ~clk;

    // Stop monitor: pops the scoreboard on every door opening and checks
    // the floor, then checks how long the door stayed open.
    initial begin
        logic  door_prev;
        int    door_len;
        int    exp_len;
        stop_t s;
        door_prev = 1'b0;
        door_len  = 0;
        exp_len   = DOOR_CYCLES;
        forever begin
            @(negedge clk);
            if (door_open && !door_prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stop_unexpected: door opened at floor %0d, no stop queued", current_floor);
                    exp_len = DOOR_CYCLES;
                end else begin
                    s = exp_q.pop_front();
                    exp_len = s.door_len;
                    if (current_floor !== FLOOR_W'(s.floor)) begin
                        errors++;
                        $display("FAIL stop_floor: got %0d expected %0d", current_floor, s.floor);
                    end
                end
                door_len = 1;
            end else if (door_open) begin
                door_len++;
            end else if (door_prev) begin
                checks++;
                if (door_len != exp_len) begin
                    errors++;
                    $display("FAIL door_len: got %0d cycles expected %0d", door_len, exp_len);
                end
            end
            door_prev = door_open;
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic push_stop(input int floor, input int len);
        stop_t s;
        s.floor    = floor;
        s.door_len = len;
        exp_q.push_back(s);
    endtask

    task automatic request(input logic [NUM_FLOORS-1:0] req);
        floor_req = req;
        tick();
        floor_req = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_floor(input int f);
        int n = 0;
        while (current_floor !== FLOOR_W'(f) && n < BUDGET) begin
            tick();
            n++;
        end
        checks++;
        if (current_floor !== FLOOR_W'(f)) begin
            errors++;
            $display("FAIL wait_floor: timed out at floor %0d waiting for %0d", current_floor, f);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        tick();
        while (!(motor_stop && !door_open && pending == '0) && n < BUDGET) begin
            tick();
            n++;
        end
        checks++;
        if (!(motor_stop === 1'b1 && door_open === 1'b0 && pending === '0)) begin
            errors++;
            $display("FAIL wait_idle: timed out, pending=%b door_open=%b", pending, door_open);
        end
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        floor_req      = '0;
        emergency_stop = 1'b0;
        tick(2);
        reset = 1'b0;
        checks++;
        if ({c_up, c_down, motor_stop, door_open, direction} !== 5'b00101 ||
            current_floor !== '0 || pending !== '0) begin
            errors++;
            $display("FAIL reset_state: up/dn/stop/door/dir=%b%b%b%b%b cf=%0d pending=%b expected 00101 cf=0 pending=0",
                     c_up, c_down, motor_stop, door_open, direction, current_floor, pending);
        end
    endtask

    // Single request from floor 0 to floor 2: exact cycle timing.
    task automatic test_single_request();
        push_stop(2, DOOR_CYCLES);
        request(8'b0000_0100);
        checks++;
        if (pending !== 8'b0000_0100 || c_up !== 1'b0) begin
            errors++;
            $display("FAIL single_latch: pending=%b c_up=%b expected 00000100 0", pending, c_up);
        end
        tick();
        checks++;
        if (c_up !== 1'b1 || current_floor !== 3'd0) begin
            errors++;
            $display("FAIL single_start: c_up=%b cf=%0d expected 1 0", c_up, current_floor);
        end
        tick(3);
        checks++;
        if (current_floor !== 3'd0) begin
            errors++;
            $display("FAIL single_early_step: cf=%0d expected 0", current_floor);
        end
        tick();
        checks++;
        if (current_floor !== 3'd1 || door_open !== 1'b0) begin
            errors++;
            $display("FAIL single_floor1: cf=%0d door=%b expected 1 0", current_floor, door_open);
        end
        tick(4);
        checks++;
        if (current_floor !== 3'd2 || door_open !== 1'b1 || pending !== '0) begin
            errors++;
            $display("FAIL single_arrive: cf=%0d door=%b pending=%b expected 2 1 0", current_floor, door_open, pending);
        end
        tick(7);
        checks++;
        if (door_open !== 1'b1) begin
            errors++;
            $display("FAIL single_door_hold: door=%b expected 1", door_open);
        end
        tick();
        checks++;
        if (door_open !== 1'b0 || motor_stop !== 1'b1 || c_up !== 1'b0 || pending !== '0) begin
            errors++;
            $display("FAIL single_idle: door=%b stop=%b c_up=%b pending=%b expected 0 1 0 0",
                     door_open, motor_stop, c_up, pending);
        end
    endtask

    // From floor 2: go up to 5, a call to 1 arrives at floor 4 -> reverse afterwards.
    task automatic test_scan_reverse();
        int n = 0;
        push_stop(5, DOOR_CYCLES);
        request(8'b0010_0000);
        wait_floor(4);
        push_stop(1, DOOR_CYCLES);
        request(8'b0000_0010);
        checks++;
        if (pending !== 8'b0010_0010 || direction !== 1'b1) begin
            errors++;
            $display("FAIL reverse_latch: pending=%b dir=%b expected 00100010 1", pending, direction);
        end
        while (c_down !== 1'b1 && n < BUDGET) begin
            tick();
            n++;
        end
        checks++;
        if (c_down !== 1'b1 || direction !== 1'b0 || current_floor !== 3'd5) begin
            errors++;
            $display("FAIL reverse_turn: c_down=%b dir=%b cf=%0d expected 1 0 5", c_down, direction, current_floor);
        end
        wait_idle();
        checks++;
        if (current_floor !== 3'd1) begin
            errors++;
            $display("FAIL reverse_end: cf=%0d expected 1", current_floor);
        end
    endtask

    // Two requests latched together from floor 0, served in order.
    task automatic test_two_stops();
        do_reset();
        push_stop(2, DOOR_CYCLES);
        push_stop(6, DOOR_CYCLES);
        request(8'b0100_0100);
        checks++;
        if (pending !== 8'b0100_0100) begin
            errors++;
            $display("FAIL two_latch: pending=%b expected 01000100", pending);
        end
        wait_idle();
        checks++;
        if (current_floor !== 3'd6 || direction !== 1'b1) begin
            errors++;
            $display("FAIL two_end: cf=%0d dir=%b expected 6 1", current_floor, direction);
        end
    endtask

    // Emergency hold mid-travel between floors 3 and 4.
    task automatic test_emergency();
        do_reset();
        push_stop(5, DOOR_CYCLES);
        request(8'b0010_0000);
        wait_floor(3);
        tick(2);
        emergency_stop = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                floor_req = 8'b1000_0000;
                push_stop(7, DOOR_CYCLES);
            end
            if (i == 4) floor_req = '0;
            tick();
            checks++;
            if (motor_stop !== 1'b1 || c_up !== 1'b0 || current_floor !== 3'd3) begin
                errors++;
                $display("FAIL emerg_hold[%0d]: stop=%b c_up=%b cf=%0d expected 1 0 3", i, motor_stop, c_up, current_floor);
            end
        end
        emergency_stop = 1'b0;
        checks++;
        if (pending !== 8'b1010_0000) begin
            errors++;
            $display("FAIL emerg_pending: pending=%b expected 10100000", pending);
        end
        tick();
        checks++;
        if (motor_stop !== 1'b1 || c_up !== 1'b0 || current_floor !== 3'd3) begin
            errors++;
            $display("FAIL emerg_release: stop=%b c_up=%b cf=%0d expected 1 0 3", motor_stop, c_up, current_floor);
        end
        tick();
        checks++;
        if (c_up !== 1'b1) begin
            errors++;
            $display("FAIL emerg_resume: c_up=%b expected 1", c_up);
        end
        tick(3);
        checks++;
        if (current_floor !== 3'd3) begin
            errors++;
            $display("FAIL emerg_discard: cf=%0d expected 3 (full floor time after release)", current_floor);
        end
        tick();
        checks++;
        if (current_floor !== 3'd4) begin
            errors++;
            $display("FAIL emerg_step: cf=%0d expected 4", current_floor);
        end
        wait_idle();
        checks++;
        if (current_floor !== 3'd7) begin
            errors++;
            $display("FAIL emerg_end: cf=%0d expected 7", current_floor);
        end
    endtask

    // Re-request the open floor at door cycle 5: absorbed, door restarts.
    task automatic test_door_restart();
        int n = 0;
        push_stop(4, 6 + DOOR_CYCLES);
        request(8'b0001_0000);
        while (door_open !== 1'b1 && n < BUDGET) begin
            tick();
            n++;
        end
        checks++;
        if (door_open !== 1'b1 || current_floor !== 3'd4) begin
            errors++;
            $display("FAIL restart_arrive: door=%b cf=%0d expected 1 4", door_open, current_floor);
        end
        tick(5);
        request(8'b0001_0000);
        checks++;
        if (pending !== '0 || door_open !== 1'b1) begin
            errors++;
            $display("FAIL restart_absorb: pending=%b door=%b expected 0 1", pending, door_open);
        end
        tick(7);
        checks++;
        if (door_open !== 1'b1) begin
            errors++;
            $display("FAIL restart_hold: door=%b expected 1", door_open);
        end
        tick();
        checks++;
        if (door_open !== 1'b0) begin
            errors++;
            $display("FAIL restart_close: door=%b expected 0", door_open);
        end
    endtask

    // Reset while moving down from 6 with requests {0,2} pending.
    task automatic test_reset_mid_travel();
        push_stop(6, DOOR_CYCLES);
        request(8'b0100_0000);
        wait_idle();
        checks++;
        if (current_floor !== 3'd6) begin
            errors++;
            $display("FAIL midreset_setup: cf=%0d expected 6", current_floor);
        end
        push_stop(2, DOOR_CYCLES);
        push_stop(0, DOOR_CYCLES);
        request(8'b0000_0101);
        wait_floor(5);
        checks++;
        if (c_down !== 1'b1 || pending !== 8'b0000_0101) begin
            errors++;
            $display("FAIL midreset_moving: c_down=%b pending=%b expected 1 00000101", c_down, pending);
        end
        do_reset();
        exp_q.delete();
        checks++;
        if (current_floor !== 3'd0 || pending !== '0 || motor_stop !== 1'b1 ||
            direction !== 1'b1 || c_down !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: cf=%0d pending=%b stop=%b dir=%b c_down=%b expected 0 0 1 1 0",
                     current_floor, pending, motor_stop, direction, c_down);
        end
    endtask

    // Request the top floor from floor 0: arrives and stays there.
    task automatic test_top_boundary();
        push_stop(NUM_FLOORS - 1, DOOR_CYCLES);
        request(8'b1000_0000);
        wait_idle();
        tick(20);
        checks++;
        if (current_floor !== 3'd7 || c_up !== 1'b0 || motor_stop !== 1'b1) begin
            errors++;
            $display("FAIL top_boundary: cf=%0d c_up=%b stop=%b expected 7 0 1", current_floor, c_up, motor_stop);
        end
    endtask

    initial begin
        test_reset();
        test_single_request();
        test_scan_reverse();
        test_two_stops();
        test_emergency();
        test_door_restart();
        test_reset_mid_travel();
        test_top_boundary();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d stops never served, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
